rc4_encrypt: RTL and testbench
==============================

Name: rc4_encrypt

Overview:
- Single-core RC4 encryptor. It runs the KSA over a 24-bit secret key, then runs the PRGA and XORs the keystream onto a plaintext ROM, writing the ciphertext into an E-RAM.
- Its ciphertext loads the encrypted-message memory that the multicore cracking cores attack, so the team can generate crack test vectors on-chip.
- Shares one 256x8 S working RAM, with the same single-port, 1-cycle-read interface the cracking cores use.

Parameters:
- MSG_LEN, 32, number of message bytes processed (1..256).
- KEY_BYTES, 3, secret key length in bytes. Key byte n is secret_key[23-8n -: 8] (MSB first).
- DROP_BYTES, 256, keystream bytes discarded when RC4_DROP_EN is defined.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin encryption. Sampled only in IDLE.
- secret_key  in  24  key; captured on an accepted start.
- busy  out  1  high from the cycle after start is accepted until done rises.
- done  out  1  high after completion; held until the next accepted start or rst.
- address_s  out  8  S RAM address.
- data_s  out  8  S RAM write data.
- wren_s  out  1  S RAM write enable.
- q_s  in  8  S RAM read data.
- address_p  out  5  plaintext ROM address (width clog2(MSG_LEN), min 1).
- q_p  in  8  plaintext ROM data.
- address_e  out  5  ciphertext RAM address.
- data_e  out  8  ciphertext RAM write data.
- wren_e  out  1  ciphertext RAM write enable.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE. busy, done, wren_s and wren_e = 0. All addresses and data = 0.
  - Internal i, j and k = 0; the latched key = 0.
  - Reset mid-run aborts immediately. S and E contents are then undefined; no further writes occur.
- Memory timing: an address presented in state X gives valid q in state X+2. Every read is followed by one WAIT state. Both q_s and q_p obey this.
- Writes take effect at the clock edge ending the state that asserts wren. Write enables are high only in write states.
- All index arithmetic is 8-bit modulo 256. key_idx = i mod KEY_BYTES.
- State sequence:
  - IDLE: when start=1, latch the key, clear done, go to INIT.
  - INIT: write S[i]=i for i=0..255, one write per cycle (256 cycles). Then i=0, j=0.
  - KSA loop, 6 cycles per i:
    - K_RD_I: present address_s = i.
    - K_WAIT_I.
    - K_CALC: si <= q_s; j <= j + q_s + key[key_idx].
    - K_RD_J: present address_s = j.
    - K_SWAP_I: sj <= q_s; write S[i] = q_s.
    - K_SWAP_J: write S[j] = si. Then i++; after i=255, set i=0, j=0, k=0 and enter PRGA.
  - PRGA loop, 11 cycles per byte:
    - P_INC: i++.
    - P_RD_I, P_WAIT_I.
    - P_CALC: si <= q_s; j += q_s.
    - P_RD_J, P_WAIT_J.
    - P_SWAP_I: write S[i] = sj.
    - P_SWAP_J: write S[j] = si.
    - P_RD_F: address_s = si + sj; address_p = k.
    - P_WAIT_F.
    - P_WR_E: address_e = k; data_e = q_s ^ q_p; wren_e = 1.
    - After P_WR_E: k++. When k = MSG_LEN-1 has been written, go to DONE.
  - DONE: busy=0, done=1. Go to IDLE in the same cycle; done stays high.
- start is ignored while busy or in any non-IDLE state.
- Start-to-done latency = 1 + 256 + 6*256 + 11*MSG_LEN cycles (exact; the bench checks it).
- Exactly MSG_LEN E-RAM writes occur, at addresses 0..MSG_LEN-1 ascending. The S RAM ends as a permutation of 0..255.

Optional Feature:
- RC4_DROP_EN: when defined, PRGA first runs DROP_BYTES iterations of P_INC..P_SWAP_J (7 cycles each) without reading the ROM or writing the E-RAM. k stays 0 during the drop phase, and latency grows by 7*DROP_BYTES. The ciphertext is the RC4-drop[DROP_BYTES] result.
- When undefined: no drop logic, and the first keystream byte encrypts plaintext byte 0.

Test Plan:
- MSG_LEN=9, secret_key=24'h4B6579, ROM "Plaintext" (50 6C 61 69 6E 74 65 78 74) -> E = BB F3 16 E8 D9 40 AF 0A D3; done after 1+256+1536+99 cycles.
- Same key, all-zero ROM, MSG_LEN=10 -> E = EB 9F 77 81 B7 34 CA 72 A7 19 (raw keystream).
- Assert rst during KSA at i=100, then start with key 24'h4B6579 -> no wren after rst; the rerun gives the same ciphertext as the first test.
- Pulse start on every cycle while busy -> exactly one run; exactly MSG_LEN wren_e pulses; latency unchanged.
- After done, check S RAM -> 256 distinct values. Apply a second start with key 24'h000000 -> done falls the next cycle and rises again after the full latency.
- With RC4_DROP_EN, DROP_BYTES=256 -> E equals a software RC4-drop256 model; latency increases by exactly 1792.

Source files
------------

// File: rtl/rc4_encrypt.sv
// rc4_encrypt: single-core RC4 encryptor.
// Runs the KSA over a 24-bit key in a shared 256x8 S RAM. It then runs the
// PRGA and XORs the keystream onto a plaintext ROM, writing the ciphertext
// into an E-RAM.
// Optional feature macro: RC4_DROP_EN. When it is defined, the first
// DROP_BYTES keystream bytes are discarded (RC4-drop[N]).
// All memory-facing outputs are registered. A value set while in state X is
// on the pins during the following cycle. The synchronous RAM samples it at
// the end of that cycle, so read data is usable two states after issue.
module rc4_encrypt #(
    parameter int MSG_LEN    = 32,
    parameter int KEY_BYTES  = 3,
    parameter int DROP_BYTES = 256,
    localparam int AW        = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [23:0]   secret_key,
    output logic          busy,
    output logic          done,
    output logic [7:0]    address_s,
    output logic [7:0]    data_s,
    output logic          wren_s,
    input  logic [7:0]    q_s,
    output logic [AW-1:0] address_p,
    input  logic [7:0]    q_p,
    output logic [AW-1:0] address_e,
    output logic [7:0]    data_e,
    output logic          wren_e
);

    typedef enum logic [4:0] {
        IDLE, INIT,
        K_RD_I, K_WAIT_I, K_CALC, K_RD_J, K_SWAP_I, K_SWAP_J,
        P_INC, P_RD_I, P_WAIT_I, P_CALC, P_RD_J, P_WAIT_J,
        P_SWAP_I, P_SWAP_J, P_RD_F, P_WAIT_F, P_WR_E,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    i_q, i_d, j_q, j_d, k_q, k_d;
    logic [7:0]    si_q, si_d, sj_q, sj_d;
    logic [23:0]   key_q, key_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [7:0]    addr_s_q, addr_s_d, data_s_q, data_s_d;
    logic          wren_s_q, wren_s_d;
    logic [AW-1:0] addr_p_q, addr_p_d, addr_e_q, addr_e_d;
    logic [7:0]    data_e_q, data_e_d;
    logic          wren_e_q, wren_e_d;
    logic [7:0]    j_sum;
    logic [7:0]    key_idx;
    logic [7:0]    key_byte;
    logic [7:0]    key_arr [KEY_BYTES];

`ifdef RC4_DROP_EN
    logic [15:0]   drop_cnt_q, drop_cnt_d;
    logic          dropping;
    assign dropping = (drop_cnt_q != 16'(DROP_BYTES));
`endif

    // Key bytes are taken MSB first from the latched key.
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key
        assign key_arr[gi] = key_q[23 - 8*gi -: 8];
    end

    // Select key[i mod KEY_BYTES] for the KSA j update.
    always_comb begin
        key_idx  = i_q % 8'(KEY_BYTES);
        key_byte = 8'h00;
        for (int n = 0; n < KEY_BYTES; n++) begin
            if (key_idx == 8'(n)) key_byte = key_arr[n];
        end
    end

    // Next-state and registered-output computation for the whole sequencer.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        si_d     = si_q;
        sj_d     = sj_q;
        key_d    = key_q;
        busy_d   = busy_q;
        done_d   = done_q;
        addr_s_d = addr_s_q;
        data_s_d = data_s_q;
        wren_s_d = 1'b0;
        addr_p_d = addr_p_q;
        addr_e_d = addr_e_q;
        data_e_d = data_e_q;
        wren_e_d = 1'b0;
        j_sum    = 8'h00;
`ifdef RC4_DROP_EN
        drop_cnt_d = drop_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = secret_key;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    i_d     = 8'h00;
                    j_d     = 8'h00;
                    k_d     = 8'h00;
                    state_d = INIT;
`ifdef RC4_DROP_EN
                    drop_cnt_d = 16'h0000;
`endif
                end
            end
            INIT: begin
                addr_s_d = i_q;
                data_s_d = i_q;
                wren_s_d = 1'b1;
                i_d      = i_q + 8'h01;
                if (i_q == 8'hFF) begin
                    j_d     = 8'h00;
                    state_d = K_RD_I;
                end
            end
            K_RD_I: begin
                addr_s_d = i_q;
                state_d  = K_WAIT_I;
            end
            K_WAIT_I: state_d = K_CALC;
            K_CALC: begin
                // The new j is issued as the read address right away so S[j]
                // is on q_s by K_SWAP_I.
                si_d     = q_s;
                j_sum    = j_q + q_s + key_byte;
                j_d      = j_sum;
                addr_s_d = j_sum;
                state_d  = K_RD_J;
            end
            K_RD_J: state_d = K_SWAP_I;
            K_SWAP_I: begin
                sj_d     = q_s;
                addr_s_d = i_q;
                data_s_d = q_s;
                wren_s_d = 1'b1;
                state_d  = K_SWAP_J;
            end
            K_SWAP_J: begin
                addr_s_d = j_q;
                data_s_d = si_q;
                wren_s_d = 1'b1;
                i_d      = i_q + 8'h01;
                if (i_q == 8'hFF) begin
                    j_d     = 8'h00;
                    k_d     = 8'h00;
                    state_d = P_INC;
                end else begin
                    state_d = K_RD_I;
                end
            end
            P_INC: begin
                i_d     = i_q + 8'h01;
                state_d = P_RD_I;
            end
            P_RD_I: begin
                addr_s_d = i_q;
                state_d  = P_WAIT_I;
            end
            P_WAIT_I: state_d = P_CALC;
            P_CALC: begin
                si_d     = q_s;
                j_sum    = j_q + q_s;
                j_d      = j_sum;
                addr_s_d = j_sum;
                state_d  = P_RD_J;
            end
            P_RD_J: begin
                // S[j] is already on q_s in the next state. The extra wait
                // is skipped while dropping so each drop round is 7 cycles.
`ifdef RC4_DROP_EN
                state_d = dropping ? P_SWAP_I : P_WAIT_J;
`else
                state_d = P_WAIT_J;
`endif
            end
            P_WAIT_J: state_d = P_SWAP_I;
            P_SWAP_I: begin
                sj_d     = q_s;
                addr_s_d = i_q;
                data_s_d = q_s;
                wren_s_d = 1'b1;
                state_d  = P_SWAP_J;
            end
            P_SWAP_J: begin
                addr_s_d = j_q;
                data_s_d = si_q;
                wren_s_d = 1'b1;
                state_d  = P_RD_F;
`ifdef RC4_DROP_EN
                if (dropping) begin
                    drop_cnt_d = drop_cnt_q + 16'h0001;
                    state_d    = P_INC;
                end
`endif
            end
            P_RD_F: begin
                addr_s_d = si_q + sj_q;
                addr_p_d = k_q[AW-1:0];
                state_d  = P_WAIT_F;
            end
            P_WAIT_F: state_d = P_WR_E;
            P_WR_E: begin
                addr_e_d = k_q[AW-1:0];
                data_e_d = q_s ^ q_p;
                wren_e_d = 1'b1;
                k_d      = k_q + 8'h01;
                state_d  = (k_q == 8'(MSG_LEN - 1)) ? DONE : P_INC;
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any run immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            i_q      <= 8'h00;
            j_q      <= 8'h00;
            k_q      <= 8'h00;
            si_q     <= 8'h00;
            sj_q     <= 8'h00;
            key_q    <= 24'h000000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_s_q <= 8'h00;
            data_s_q <= 8'h00;
            wren_s_q <= 1'b0;
            addr_p_q <= '0;
            addr_e_q <= '0;
            data_e_q <= 8'h00;
            wren_e_q <= 1'b0;
`ifdef RC4_DROP_EN
            drop_cnt_q <= 16'h0000;
`endif
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            key_q    <= key_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_s_q <= addr_s_d;
            data_s_q <= data_s_d;
            wren_s_q <= wren_s_d;
            addr_p_q <= addr_p_d;
            addr_e_q <= addr_e_d;
            data_e_q <= data_e_d;
            wren_e_q <= wren_e_d;
`ifdef RC4_DROP_EN
            drop_cnt_q <= drop_cnt_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign address_s = addr_s_q;
    assign data_s    = data_s_q;
    assign wren_s    = wren_s_q;
    assign address_p = addr_p_q;
    assign address_e = addr_e_q;
    assign data_e    = data_e_q;
    assign wren_e    = wren_e_q;

endmodule

// File: tb/tb_rc4_encrypt.sv
// tb_rc4_encrypt: scoreboard bench for rc4_encrypt.
// The stimulus pushes the expected E-RAM writes and the expected latency for
// each run, computed by a plain software RC4 model. A negedge monitor pops and
// compares them as the DUT writes. Also honours RC4_DROP_EN.
module tb_rc4_encrypt;

    localparam int MSG_LEN = 32;
    localparam int AW      = 5;
`ifdef RC4_DROP_EN
    localparam int DROP = 256;
`else
    localparam int DROP = 0;
`endif
    localparam int LAT = 1 + 256 + 6*256 + 11*MSG_LEN + 7*DROP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [23:0]   secret_key = 24'h0;
    logic          busy, done, wren_s, wren_e;
    logic [7:0]    address_s, data_s, data_e;
    logic [7:0]    q_s = 8'h00;
    logic [7:0]    q_p = 8'h00;
    logic [AW-1:0] address_p, address_e;

    rc4_encrypt #(.MSG_LEN(MSG_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .secret_key(secret_key),
        .busy(busy), .done(done),
        .address_s(address_s), .data_s(data_s), .wren_s(wren_s), .q_s(q_s),
        .address_p(address_p), .q_p(q_p),
        .address_e(address_e), .data_e(data_e), .wren_e(wren_e)
    );

    always #5 clk = ~clk;

    // Memory models: synchronous single-port RAMs and ROM, read-old-data.
    logic [7:0] s_mem [256];
    logic [7:0] rom   [MSG_LEN];
    logic [7:0] eram  [MSG_LEN];
    always @(posedge clk) begin
        if (wren_s) s_mem[address_s] <= data_s;
        q_s <= s_mem[address_s];
        q_p <= rom[address_p];
        if (wren_e) eram[address_e] <= data_e;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: event not expected or bound expired", name);
    endtask

    // Reference RC4 (optionally with drop) in plain integer arithmetic.
    int model_ks [256];
    int model_s  [256];
    task automatic rc4_model(input logic [23:0] key, input int drop);
        int s [256];
        int i, j, t, kb;
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            kb = int'((key >> (8 * (2 - (x % 3)))) & 24'hFF);
            j = (j + s[x] + kb) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0; j = 0;
        for (int c = 0; c < drop + MSG_LEN; c++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (c >= drop) model_ks[c - drop] = s[(s[i] + s[j]) % 256];
        end
        for (int x = 0; x < 256; x++) model_s[x] = s[x];
    endtask

    typedef struct { int addr; int data; } ewr_t;
    ewr_t exp_q [$];
    int   lat_q [$];

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: E writes, run starts, completion latency.
    int   start_cyc = 0;
    int   n_runs = 0, n_wren_s = 0, n_wren_e = 0;
    logic busy_prev = 1'b0, done_prev = 1'b0;
    always @(negedge clk) begin
        ewr_t e;
        if (wren_s) n_wren_s++;
        if (wren_e) begin
            n_wren_e++;
            if (exp_q.size() == 0) begin
                fail_now("spurious_e_write");
            end else begin
                e = exp_q.pop_front();
                check("e_addr", 32'(address_e), 32'(e.addr));
                check("e_data", 32'(data_e), 32'(e.data));
                $display("E write addr %0d data %02h (expected %02h)", address_e, data_e, e.data);
            end
        end
        if (busy && !busy_prev) begin
            start_cyc = cyc;
            n_runs++;
        end
        if (done && !done_prev) begin
            if (lat_q.size() == 0) begin
                fail_now("spurious_done");
            end else begin
                check("latency", 32'(cyc - start_cyc), 32'(lat_q.pop_front()));
                check("all_e_writes_seen", 32'(exp_q.size()), 32'd0);
                $display("run done after %0d cycles", cyc - start_cyc);
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    // Issue a start from a negedge; queue expectations from the model.
    task automatic do_start(input logic [23:0] key, input bit hold);
        rc4_model(key, DROP);
        for (int a = 0; a < MSG_LEN; a++)
            exp_q.push_back('{a, int'(rom[a] ^ 8'(model_ks[a]))});
        lat_q.push_back(LAT);
        secret_key = key;
        start = 1'b1;
        @(negedge clk);
        if (!hold) begin
            start = 1'b0;
            secret_key = 24'($urandom);
        end
    endtask

    task automatic wait_done();
        for (int c = 0; c < LAT + 50; c++) begin
            if (done) break;
            @(negedge clk);
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    logic [7:0] pt   [9]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct_a [9]  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] ks_a [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};

    task automatic load_plaintext();
        for (int a = 0; a < MSG_LEN; a++) rom[a] = (a < 9) ? pt[a] : 8'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w_s0, w_e0, r0, distinct, mism;
        logic [255:0] seen;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_wren_s", 32'(wren_s), 32'd0);
        check("rst_wren_e", 32'(wren_e), 32'd0);
        check("rst_address_s", 32'(address_s), 32'd0);
        check("rst_data_s", 32'(data_s), 32'd0);
        check("rst_address_p", 32'(address_p), 32'd0);
        check("rst_address_e", 32'(address_e), 32'd0);
        check("rst_data_e", 32'(data_e), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known-answer run: key "Key", plaintext "Plaintext".
        load_plaintext();
        do_start(24'h4B6579, 1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        wait_done();
`ifndef RC4_DROP_EN
        for (int a = 0; a < 9; a++) check("kat_plaintext", 32'(eram[a]), 32'(ct_a[a]));
`endif
        seen = '0;
        distinct = 0;
        mism = 0;
        for (int x = 0; x < 256; x++) begin
            if (!seen[s_mem[x]]) distinct++;
            seen[s_mem[x]] = 1'b1;
            if (int'(s_mem[x]) != model_s[x]) mism++;
        end
        check("s_distinct", 32'(distinct), 32'd256);
        check("s_matches_model", 32'(mism), 32'd0);

        // All-zero plaintext exposes the raw keystream.
        repeat (2) @(negedge clk);
        for (int a = 0; a < MSG_LEN; a++) rom[a] = 8'h00;
        do_start(24'h4B6579, 1'b0);
        wait_done();
`ifndef RC4_DROP_EN
        for (int a = 0; a < 10; a++) check("kat_keystream", 32'(eram[a]), 32'(ks_a[a]));
`endif

        // Abort during the KSA at about i=100; no writes after reset.
        repeat (2) @(negedge clk);
        load_plaintext();
        do_start(24'h4B6579, 1'b0);
        repeat (256 + 6*100) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_wren_s", 32'(wren_s), 32'd0);
        check("abort_wren_e", 32'(wren_e), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        w_s0 = n_wren_s;
        w_e0 = n_wren_e;
        repeat (20) @(negedge clk);
        check("no_wren_s_after_rst", 32'(n_wren_s - w_s0), 32'd0);
        check("no_wren_e_after_rst", 32'(n_wren_e - w_e0), 32'd0);
        do_start(24'h4B6579, 1'b0);
        wait_done();
`ifndef RC4_DROP_EN
        for (int a = 0; a < 9; a++) check("rerun_plaintext", 32'(eram[a]), 32'(ct_a[a]));
`endif

        // start held high throughout the run: exactly one run.
        repeat (2) @(negedge clk);
        for (int a = 0; a < MSG_LEN; a++) rom[a] = 8'($urandom);
        r0 = n_runs;
        w_e0 = n_wren_e;
        do_start(24'($urandom), 1'b1);
        for (int c = 0; c < LAT + 50; c++) begin
            if (done) break;
            @(negedge clk);
        end
        start = 1'b0;
        check("held_start_done", 32'(done), 32'd1);
        repeat (4) @(negedge clk);
        check("held_start_runs", 32'(n_runs - r0), 32'd1);
        check("held_start_e_writes", 32'(n_wren_e - w_e0), 32'(MSG_LEN));

        // Restart with key 0 after done: done drops, then returns.
        do_start(24'h000000, 1'b0);
        check("done_falls", 32'(done), 32'd0);
        wait_done();

        // Random keys and plaintexts.
        for (int r = 0; r < 2; r++) begin
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
            for (int a = 0; a < MSG_LEN; a++) rom[a] = 8'($urandom);
            do_start(24'($urandom), 1'b0);
            wait_done();
        end

        repeat (3) @(negedge clk);
        check("queues_empty", 32'(exp_q.size() + lat_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
